// File: rtl/svlib_reg_pkg.sv
// Shared helpers for the svlib register library.
// Occupancy width and parameter legality checks.
package svlib_reg_pkg;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit width_ok(input int w);
        return w >= 1;
    endfunction

    function automatic bit depth_ok(input int d);
        return d >= 1;
    endfunction

endpackage

// File: rtl/register_pipe_en_sync_rstn_stage.sv
// One valid/data stage of the elastic register pipeline.
// Data holds on bubbles so the payload never toggles needlessly.
module register_pipe_stage
    import svlib_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             rdy_in,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             v_o,
    output logic [WIDTH-1:0] d_o
);

    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush) begin
            v_d = 1'b0;
        end else if (rdy_in) begin
            v_d = up_valid;
            if (up_valid) begin
                d_d = up_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v_q <= 1'b0;
            d_q <= RESET_VAL;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v_o = v_q;
    assign d_o = d_q;

endmodule

// File: rtl/register_pipe_en_sync_rstn.sv
// Elastic DEPTH-stage register pipeline with valid/ready and flush.
// REGISTER_PIPE_OCC_EN adds the occupancy port and counter.
module register_pipe_en_sync_rstn
    import svlib_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef REGISTER_PIPE_OCC_EN
    output logic [WIDTH-1:0]        out_data,
    output logic [occ_w(DEPTH)-1:0] occupancy
`else
    output logic [WIDTH-1:0]        out_data
`endif
);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("register_pipe_en_sync_rstn: WIDTH must be >= 1");
    end
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("register_pipe_en_sync_rstn: DEPTH must be >= 1");
    end

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] up_d [DEPTH];
    logic [WIDTH-1:0] d    [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        // A stage may move if any stage at or ahead of it is empty.
        assign rdy[i] = out_ready | ~(&v[DEPTH-1:i]);

        if (i == 0) begin : g_head
            assign up_v[i] = in_valid;
            assign up_d[i] = in_data;
        end else begin : g_body
            assign up_v[i] = v[i-1];
            assign up_d[i] = d[i-1];
        end

        register_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .rstn     (rstn),
            .flush    (flush),
            .rdy_in   (rdy[i]),
            .up_valid (up_v[i]),
            .up_data  (up_d[i]),
            .v_o      (v[i]),
            .d_o      (d[i])
        );
    end

    assign in_ready  = rstn & ~flush & rdy[0];
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

`ifdef REGISTER_PIPE_OCC_EN
    localparam int OW = occ_w(DEPTH);

    logic          in_fire, out_fire;
    logic [OW-1:0] occ_q, occ_d;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + OW'(in_fire) - OW'(out_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule
